// File: rtl/sat_ctrl_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_ctrl_gen                                                             |
// | Byte-serial 32-bit add/sub with overflow and saturation-control outputs. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sat_ctrl_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        sub,
    input  logic        sgn,
    input  logic        sat_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic [1:0]  out_lane,
    output logic        sat_enable,
    output logic        sat_sign,
    output logic        sat_last,
    output logic        ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0][7:0] a_q, a_d;
    logic [3:0][7:0] b_q, b_d;
    logic            sub_q, sub_d;
    logic            sgn_q, sgn_d;
    logic            sat_mode_q, sat_mode_d;
    logic [1:0]      lane_q, lane_d;
    logic            carry_q, carry_d;
    logic [3:0][7:0] buf_q, buf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_byte_q, out_byte_d;
    logic [1:0]      out_lane_q, out_lane_d;
    logic            sat_enable_q, sat_enable_d;
    logic            sat_sign_q, sat_sign_d;
    logic            sat_last_q, sat_last_d;
    logic            ovf_q, ovf_d;

    logic [8:0]      w_sum;
    logic            w_ovf;
    logic            w_sat_en;
    logic            w_sat_dir;
    logic [1:0]      w_next_lane;

    // b_q already holds the effective operand (inverted for subtraction)
    assign w_sum       = {1'b0, a_q[lane_q]} + {1'b0, b_q[lane_q]} + {8'd0, carry_q};
    assign w_ovf       = sgn_q ? ((a_q[3][7] == b_q[3][7]) && (w_sum[7] != a_q[3][7]))
                               : (w_sum[8] ^ sub_q);
    assign w_sat_en    = sat_mode_q & w_ovf;
    assign w_sat_dir   = sgn_q ? a_q[3][7] : sub_q;
    assign w_next_lane = out_lane_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sub_d        = sub_q;
        sgn_d        = sgn_q;
        sat_mode_d   = sat_mode_q;
        lane_d       = lane_q;
        carry_d      = carry_q;
        buf_d        = buf_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        out_lane_d   = out_lane_q;
        sat_enable_d = sat_enable_q;
        sat_sign_d   = sat_sign_q;
        sat_last_d   = sat_last_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = op_a;
                    b_d        = sub ? ~op_b : op_b;
                    sub_d      = sub;
                    sgn_d      = sgn;
                    sat_mode_d = sat_mode;
                    carry_d    = sub;
                    lane_d     = 2'd0;
                    in_ready_d = 1'b0;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                buf_d[lane_q] = w_sum[7:0];
                carry_d       = w_sum[8];
                lane_d        = lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    // lane 0 is already in the buffer, so emission starts right away
                    ovf_d        = w_ovf;
                    sat_enable_d = w_sat_en;
                    sat_sign_d   = w_sat_en & w_sat_dir;
                    sat_last_d   = 1'b0;
                    out_valid_d  = 1'b1;
                    out_lane_d   = 2'd0;
                    out_byte_d   = buf_q[0];
                    state_d      = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (out_lane_q == 2'd3) begin
                        out_valid_d  = 1'b0;
                        out_byte_d   = 8'd0;
                        out_lane_d   = 2'd0;
                        sat_enable_d = 1'b0;
                        sat_sign_d   = 1'b0;
                        sat_last_d   = 1'b0;
                        in_ready_d   = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        out_lane_d = w_next_lane;
                        out_byte_d = buf_q[w_next_lane];
                        sat_last_d = sat_enable_q & sgn_q & (w_next_lane == 2'd3);
                    end
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            sgn_q        <= 1'b0;
            sat_mode_q   <= 1'b0;
            lane_q       <= 2'd0;
            carry_q      <= 1'b0;
            buf_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'd0;
            out_lane_q   <= 2'd0;
            sat_enable_q <= 1'b0;
            sat_sign_q   <= 1'b0;
            sat_last_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            sgn_q        <= sgn_d;
            sat_mode_q   <= sat_mode_d;
            lane_q       <= lane_d;
            carry_q      <= carry_d;
            buf_q        <= buf_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            out_lane_q   <= out_lane_d;
            sat_enable_q <= sat_enable_d;
            sat_sign_q   <= sat_sign_d;
            sat_last_q   <= sat_last_d;
            ovf_q        <= ovf_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign out_lane   = out_lane_q;
    assign sat_enable = sat_enable_q;
    assign sat_sign   = sat_sign_q;
    assign sat_last   = sat_last_q;
    assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: doc/sat_ctrl_gen.md
SAT_CTRL_GEN -- requirements
Module: sat_ctrl_gen

Interface
REQ-001 SHALL have one clock and one reset: the clock is clk; the reset is rst_n, asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand transaction offered.
REQ-005 in_ready  output  1  block idle, will capture operands.
REQ-006 op_a  input  32  operand A.
REQ-007 op_b  input  32  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 sgn  input  1  0 = unsigned arithmetic, 1 = two's-complement.
REQ-010 sat_mode  input  1  1 = request saturation controls on overflow.
REQ-011 out_valid  output  1  byte lane presented.
REQ-012 out_ready  input  1  downstream accepts current lane.
REQ-013 out_byte  output  8  raw (unsaturated) result byte for the current lane.
REQ-014 out_lane  output  2  lane index, 0 = least significant.
REQ-015 sat_enable / sat_sign / sat_last  output  1 each  saturation controls for the current lane.
REQ-016 ovf  output  1  overflow flag of the current result.

Function
REQ-017 SHALL implement FSM IDLE -> CALC -> EMIT -> IDLE; in_ready = 1 only in IDLE.
REQ-018 SHALL capture op_a, op_b, sub, sgn, sat_mode on the edge where in_valid && in_ready, then enter CALC.
REQ-019 CALC SHALL take exactly 4 cycles, lanes 0..3 in order: byte = A[k] + (sub ? ~B[k] : B[k]) + carry, 9-bit internal sum, with carry initialised to sub; each byte is stored in a 4-byte buffer.
REQ-020 At the end of lane 3 ovf SHALL be: unsigned add -> carry-out; unsigned sub -> NOT carry-out; signed -> (A31 == B'31) && (R31 != A31), where B' = the effective B after optional inversion.
REQ-021 Saturation direction SHALL be: unsigned add -> high (sat_sign = 0); unsigned sub -> low (sat_sign = 1); signed -> sat_sign = A31 (0 = positive overflow, 1 = negative overflow).
REQ-022 sat_enable SHALL equal sat_mode && ovf for every lane of the transaction.
REQ-023 sat_last SHALL equal sat_enable && sgn && (out_lane == 3); with these controls, downstream saturation yields 0xFFFFFFFF, 0x00000000, 0x7FFFFFFF or 0x80000000.
REQ-024 When sat_enable = 0, sat_sign and sat_last SHALL be 0.
REQ-025 EMIT SHALL assert out_valid starting with lane 0 on the cycle after the 4th CALC cycle, so out_valid rises 5 edges after capture.
REQ-026 EMIT SHALL advance the lane on each edge with out_valid && out_ready.
REQ-027 While out_valid && !out_ready, out_byte, out_lane, the sat controls and ovf SHALL hold stable.
REQ-028 On acceptance of lane 3, out_valid SHALL drop and the FSM SHALL return to IDLE, with in_ready = 1 in the next cycle; in_valid in that same cycle is not captured.
REQ-029 Throughput SHALL be 9 cycles per transaction with out_ready held high.
REQ-030 ovf SHALL be valid throughout EMIT and hold its value in IDLE until the next capture.
REQ-031 Inputs op_a, op_b, sub, sgn, sat_mode SHALL be ignored outside the capture edge.

Reset
REQ-032 rst_n low SHALL immediately force IDLE: in_ready = 1; out_valid, out_byte, out_lane, sat_enable, sat_sign, sat_last and ovf = 0; buffer and carry cleared.
REQ-033 Reset asserted in CALC or EMIT SHALL abort the transaction with no further lanes emitted.
REQ-034 After rst_n rises, the first capture SHALL behave identically to a capture after power-up.

Verification
REQ-035 Unsigned add 0xFFFFFFFF+0x00000001, sat_mode=1 -> lanes 0-3 out_byte 00,00,00,00; ovf=1; sat_enable=1, sat_sign=0, sat_last=0 on all lanes.
REQ-036 Signed add 0x7FFFFFFF+0x00000001, sat_mode=1 -> bytes 00,00,00,80; ovf=1; sat_sign=0; sat_last=1 on lane 3 only.
REQ-037 Signed sub 0x80000000-0x00000001, sat_mode=1 -> bytes FF,FF,FF,7F; ovf=1; sat_sign=1; sat_last=1 on lane 3 only.
REQ-038 Unsigned sub 0x00000005-0x00000007, sat_mode=1 -> bytes FE,FF,FF,FF; ovf=1; sat_sign=1, sat_last=0. Repeated with sat_mode=0 -> ovf=1 and all sat controls 0.
REQ-039 Unsigned add 0x12345678+0x11111111 -> bytes 89,67,45,23 and sat_enable=0; out_ready held low 3 cycles at lane 1 -> lane 1 outputs remain stable; no lane is skipped or duplicated.
REQ-040 rst_n pulsed low during EMIT lane 2 -> out_valid=0 and in_ready=1 immediately; a following transaction 0x00000001+0x00000001 -> bytes 02,00,00,00 with ovf=0.
